// File: rtl/tnn_stream_classifier.sv
// Streaming two-layer ternary neural network classifier.
// Features arrive one per beat; every hidden neuron accumulates in parallel.
// A single-cycle output layer then produces a 1-bit class, which is held on a
// valid/ready result port until the consumer takes it.

// One hidden neuron: signed accumulator that starts at its bias and adds
// w * x for each accepted feature, where w is a ternary weight.
module tnn_hid_lane #(
  parameter int W     = 2,
  parameter int B_W   = 8,
  parameter int ACC_W = 13,
  parameter logic [B_W-1:0] BIAS = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reload,
  input  logic         add,
  input  logic [1:0]   wt,
  input  logic [W-1:0] data,
  output logic         nonneg
);
  localparam logic [ACC_W-1:0] BIAS_X = {{(ACC_W-B_W){BIAS[B_W-1]}}, BIAS};

  logic [ACC_W-1:0] acc_q, acc_d, term, data_x;

  // Ternary product, then reload/accumulate/hold selection.
  always_comb begin
    data_x = {{(ACC_W-W){1'b0}}, data};
    term   = '0;
    if (wt == 2'b01)      term = data_x;
    else if (wt == 2'b11) term = -data_x;
    acc_d = acc_q;
    if (reload)   acc_d = BIAS_X;
    else if (add) acc_d = acc_q + term;
  end

  // Accumulator register; reset loads the bias so IDLE needs no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= BIAS_X;
    else        acc_q <= acc_d;
  end

  assign nonneg = ~acc_q[ACC_W-1];
endmodule

module tnn_stream_classifier #(
  parameter int N_FEAT = 5,
  parameter int W      = 2,
  parameter int N_HID  = 2,
  parameter int B_W    = 8,
  parameter logic [2*N_FEAT*N_HID-1:0] W1 = 20'hFFD55,
  parameter logic [N_HID*B_W-1:0]      B1 = 16'h03FC,
  parameter logic [2*N_HID-1:0]        W2 = 4'hD,
  parameter logic [B_W-1:0]            B2 = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_class,
  output logic         frame_err
);
  localparam int ACC_W = B_W + W + $clog2(N_FEAT+1);
  localparam int IDX_W = $clog2(N_FEAT);
  localparam int S_W   = B_W + $clog2(N_HID+1) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT-1);
  localparam logic [S_W-1:0]   ONE_S    = {{(S_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACCUM, L2, OUT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_class_q, out_class_d;
  logic             frame_err_q, frame_err_d;
  logic             hs, is_final, err, done, reload, add;
  logic [N_HID-1:0] h;
  logic [S_W-1:0]   s;

  assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid = (state_q == OUT);
  assign out_class = out_class_q;
  assign frame_err = frame_err_q;

  assign hs       = in_valid & in_ready;
  assign is_final = (idx_q == LAST_IDX);
  // in_last must coincide exactly with the final feature index.
  assign err      = hs & (in_last != is_final);
  assign done     = hs & in_last & is_final;
  assign reload   = err | ((state_q == OUT) & out_ready);
  assign add      = hs & ~err;

  for (genvar j = 0; j < N_HID; j++) begin : g_hid
    localparam logic [2*N_FEAT-1:0] WROW = W1[2*j*N_FEAT +: 2*N_FEAT];
    logic [N_FEAT-1:0][1:0] wrow;
    assign wrow = WROW;
    tnn_hid_lane #(
      .W(W), .B_W(B_W), .ACC_W(ACC_W), .BIAS(B1[j*B_W +: B_W])
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .reload(reload),
      .add   (add),
      .wt    (wrow[idx_q]),
      .data  (in_data),
      .nonneg(h[j])
    );
  end

  // Output layer: s = B2 + sum of ternary W2 over binary hidden activations.
  always_comb begin
    s = {{(S_W-B_W){B2[B_W-1]}}, B2};
    for (int j = 0; j < N_HID; j++) begin
      if (h[j] && W2[2*j +: 2] == 2'b01)      s = s + ONE_S;
      else if (h[j] && W2[2*j +: 2] == 2'b11) s = s - ONE_S;
    end
  end

  // Frame sequencing, frame-error detection and result capture.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_class_d = out_class_q;
    frame_err_d = err;
    case (state_q)
      IDLE, ACCUM: begin
        if (hs) begin
          if (err) begin
            state_d = IDLE;
            idx_d   = '0;
          end else if (done) begin
            state_d = L2;
            idx_d   = '0;
          end else begin
            state_d = ACCUM;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      L2: begin
        out_class_d = ~s[S_W-1];
        state_d     = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_class_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_class_q <= out_class_d;
      frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_tnn_stream_classifier.sv
// Directed bench for tnn_stream_classifier with the default weights:
// hidden 0 all +1 bias -4, hidden 1 all -1 bias +3, W2 = {+1, -1}, B2 = 0.
module tb_tnn_stream_classifier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_class;
  logic       frame_err;

  int vectors = 0;
  int miscompares = 0;

  tnn_stream_classifier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send n beats of f; in_last on index last_at (-1 = never). With gaps,
  // idle cycles carrying junk data and in_last are inserted between beats.
  task automatic send(input logic [4:0][1:0] f, input int n, input int last_at,
                      input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          in_valid = 1'b0;
          in_data  = 2'($urandom_range(0, 3));
          in_last  = 1'b1;
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = f[i];
      in_last  = (i == last_at);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full frame; result appears in the second cycle after the last beat's
  // cycle (one L2 cycle in between).
  task automatic frame_expect(input string tag, input logic [4:0][1:0] f,
                              input logic exp, input bit gaps);
    send(f, 5, 4, gaps);
    chk({tag, "_l2_valid"}, out_valid, 1'b0);
    chk({tag, "_l2_ready"}, in_ready, 1'b0);
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_class"}, out_class, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 1'b0);
    chk({tag, "_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    // Reset state, asserted from time 0.
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_class", out_class, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // acc = {-4, 3} -> h = {0,1} -> s = -1 -> class 0
    frame_expect("zeros", {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, 1'b0);
    // acc0 = -1, acc1 = 0 -> s = -1 -> class 0
    frame_expect("b11100", {2'd0, 2'd0, 2'd1, 2'd1, 2'd1}, 1'b0, 1'b0);
    // acc0 = 0, acc1 = -1 -> s = +1 -> class 1
    frame_expect("b11110", {2'd0, 2'd1, 2'd1, 2'd1, 2'd1}, 1'b1, 1'b0);

    // Backpressure: all 3s -> acc0 = 11, acc1 = -12 -> class 1.
    send({2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 5, 4, 1'b0);
    tick();
    in_valid = 1'b1;
    in_data  = 2'd0;
    in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_class", out_class, 1'b1);
      chk("bp_ready", in_ready, 1'b0);
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_drop", out_valid, 1'b0);
    chk("bp_noerr", frame_err, 1'b0);
    // A swallowed extra beat would misalign this frame.
    frame_expect("after_bp", {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, 1'b0);

    // Early in_last on the third beat.
    send({2'd0, 2'd0, 2'd1, 2'd1, 2'd1}, 3, 2, 1'b0);
    chk("early_err", frame_err, 1'b1);
    chk("early_ready", in_ready, 1'b1);
    chk("early_valid", out_valid, 1'b0);
    tick();
    chk("early_pulse", frame_err, 1'b0);
    chk("early_valid2", out_valid, 1'b0);
    frame_expect("after_early", {2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 1'b1, 1'b0);

    // Missing in_last on the fifth beat.
    send({2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 5, -1, 1'b0);
    chk("nolast_err", frame_err, 1'b1);
    chk("nolast_valid", out_valid, 1'b0);
    tick();
    chk("nolast_pulse", frame_err, 1'b0);
    chk("nolast_valid2", out_valid, 1'b0);
    frame_expect("gaps", {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, 1'b1);

    // Reset after two beats of 3: stale partials would flip the next result.
    send({2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 2, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_err", frame_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    frame_expect("after_mrst", {2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1'b0, 1'b0);

    // Reset while holding a class-1 result.
    send({2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 5, 4, 1'b0);
    tick();
    chk("orst_pre", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("orst_valid", out_valid, 1'b0);
    chk("orst_class", out_class, 1'b0);
    chk("orst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    frame_expect("after_orst", {2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
